acc_alu_seq: RTL

//  Next-generation accumulator ALU for picoMips cores: parametrised width, fixed-point
//  (Q-format) arithmetic, and an iterative shift-add multiplier in place of a

---
 rtl/alu_pkg.sv | 23 ++
 rtl/seq_mul.sv | 71 +++++++
 rtl/acc_alu_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the accumulator ALU: opcode and operand-select
// encodings, the control FSM states and a signed clamp used for saturation.
package alu_pkg;

  typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB, OP_MUL} op_t;
  typedef enum logic [1:0] {SEL_IMM, SEL_SW, SEL_REG, SEL_ZERO} opsel_t;
  typedef enum logic {IDLE, MUL} state_t;

  // Wide enough for any intermediate result at WIDTH=32 (2*32+1 bits).
  localparam int WIDE_W = 65;

  function automatic logic signed [WIDE_W-1:0] sat_clip(input logic signed [WIDE_W-1:0] v,
                                                        input int w);
    logic signed [WIDE_W-1:0] one, hi, lo;
    one = 1;
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative sign-magnitude shift-add multiplier: one partial product per cycle,
// WIDTH cycles per operation, exact 2*WIDTH-bit signed product.
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      busy,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  logic signed [WIDTH:0] a_ext, b_ext;
  logic [WIDTH:0]        a_mag, b_mag, pb;
  logic [PW-1:0]         pa, psum, step_sum;
  logic                  neg;
  logic [CW-1:0]         cnt;

  // One extra bit so that |-2^(WIDTH-1)| is representable as a magnitude.
  assign a_ext = {a[WIDTH-1], a};
  assign b_ext = {b[WIDTH-1], b};
  assign a_mag = a[WIDTH-1] ? $unsigned(-a_ext) : $unsigned(a_ext);
  assign b_mag = b[WIDTH-1] ? $unsigned(-b_ext) : $unsigned(b_ext);

  // The last step is folded in combinationally so the result is ready at the
  // edge that ends the WIDTH-th busy cycle.
  assign step_sum = psum + (pb[0] ? pa : '0);
  assign done     = busy && (cnt == CW'(WIDTH - 1));
  assign product  = neg ? -$signed(step_sum) : $signed(step_sum);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; datapath registers are reset too, keeping X out of product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      pa   <= '0;
      pb   <= '0;
      psum <= '0;
      neg  <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
      psum <= '0;
      pa   <= PW'(a_mag);
      pb   <= b_mag;
      neg  <= a[WIDTH-1] ^ b[WIDTH-1];
    end else if (busy) begin
      psum <= step_sum;
      pa   <= pa << 1;
      pb   <= pb >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/acc_alu_seq.sv
// Accumulator ALU with Q-format scaling, optional saturation and an iterative
// multiplier behind a Start/Busy/Done handshake with abort.
module acc_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4,
  parameter int SAT   = 1
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  op_t              Op,
  input  opsel_t           OpSel,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Imm,
  input  logic [WIDTH-1:0] SW,
  input  logic [WIDTH-1:0] RegData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ACC,
  output logic             Ovf,
  output logic             Zero
);

  state_t                    state_q, state_d;
  logic signed [WIDTH-1:0]   acc_q, operand, result;
  logic signed [2*WIDTH-1:0] product, scaled;
  logic signed [WIDE_W-1:0]  wide, clipped;
  logic                      accept, mul_start, mul_abort, mul_busy, mul_done;
  logic                      done_q, ovf_q, ovf_d;

  assign accept    = Start && (state_q == IDLE) && !mul_busy;
  assign mul_start = accept && (Op == OP_MUL);
  assign mul_abort = Abort && (state_q == MUL);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    operand = '0;
    case (OpSel)
      SEL_IMM:  operand = Imm;
      SEL_SW:   operand = SW;
      SEL_REG:  operand = RegData;
      default:  operand = '0;
    endcase
  end

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (Clock),
    .rst_n   (nReset),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (acc_q),
    .b       (operand),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (Abort || mul_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Full-precision result before clamping or wrapping; size casts sign-extend.
  assign scaled = product >>> FRAC;

  always_comb begin
    wide = '0;
    if (state_q == MUL) begin
      wide = WIDE_W'(scaled);
    end else begin
      case (Op)
        OP_LOAD: wide = WIDE_W'(operand);
        OP_ADD:  wide = WIDE_W'(acc_q) + WIDE_W'(operand);
        OP_SUB:  wide = WIDE_W'(acc_q) - WIDE_W'(operand);
        default: wide = '0;
      endcase
    end
  end

  assign clipped = sat_clip(wide, WIDTH);
  assign result  = (SAT != 0) ? clipped[WIDTH-1:0] : wide[WIDTH-1:0];
  assign ovf_d   = (clipped != wide);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && (Op != OP_MUL)) begin
        acc_q  <= result;
        ovf_q  <= ovf_d;
        done_q <= 1'b1;
      end else if ((state_q == MUL) && !Abort && mul_done) begin
        acc_q  <= result;
        ovf_q  <= ovf_d;
        done_q <= 1'b1;
      end
    end
  end

  assign Busy = (state_q == MUL);
  assign Done = done_q;
  assign ACC  = acc_q;
  assign Ovf  = ovf_q;
  assign Zero = (acc_q == '0);

endmodule
